// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock divider: default widths,
// the post-reset half-period and ready-made terminal counts for common rates.
package clk_div_pkg;

  localparam int CNT_W_DEF    = 33;
  localparam int RST_HALF_DEF = 50000;

  localparam longint unsigned SYS_CLK_HZ = 64'd100_000_000;

  // Terminal count N such that out_clk runs at out_hz: half-period is N+1 cycles.
  function automatic longint unsigned half_count(input longint unsigned clk_hz,
                                                 input longint unsigned out_hz);
    return (clk_hz / (2 * out_hz)) - 1;
  endfunction

  localparam longint unsigned HALF_1KHZ = half_count(SYS_CLK_HZ, 64'd1000);
  localparam longint unsigned HALF_1HZ  = half_count(SYS_CLK_HZ, 64'd1);

endpackage

// File: rtl/clk_div_if.sv
// Control and status bundle of the programmable divider; the controller side
// drives enable/clear/divisor loads, the divider returns clock and strobes.
interface clk_div_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             enable;
  logic             clear;
  logic             div_load;
  logic [CNT_W-1:0] div_value;

  logic             out_clk;
  logic             tick;
  logic             rise_tick;
  logic             fall_tick;
  logic             pending;

  modport master (
    output enable, clear, div_load, div_value,
    input  out_clk, tick, rise_tick, fall_tick, pending
  );

  modport slave (
    input  enable, clear, div_load, div_value,
    output out_clk, tick, rise_tick, fall_tick, pending
  );

endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable divider: 50 % duty out_clk plus single-cycle strobes,
// with a shadowed divisor that only switches on a half-period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int RST_HALF = RST_HALF_DEF
) (
  input  logic       in_clk,
  input  logic       rst_n,
  clk_div_if.slave   bus
);

  localparam logic [CNT_W-1:0] RST_N_VAL = CNT_W'(RST_HALF);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] count,    count_d;
  logic [CNT_W-1:0] active_n, active_d;
  logic [CNT_W-1:0] shadow_n, shadow_d;
  logic             pending_q, pending_d;
  logic             out_q,     out_d;
  logic             tick_q,    tick_d;
  logic             rise_q,    rise_d;
  logic             fall_q,    fall_d;
  logic             terminal;

  // A count past active_n cannot occur, but treating it as terminal keeps
  // the divider self-recovering should it ever happen.
  assign terminal = (count >= active_n);

  // A load is folded into the shadow first, so a load landing on the
  // boundary (or on a clear) is applied there instead of waiting a half-period.
  always_comb begin
    count_d   = count;
    active_d  = active_n;
    shadow_d  = shadow_n;
    pending_d = pending_q;
    out_d     = out_q;
    tick_d    = 1'b0;
    rise_d    = 1'b0;
    fall_d    = 1'b0;

    if (bus.div_load) begin
      shadow_d  = bus.div_value;
      pending_d = 1'b1;
    end

    if (bus.clear) begin
      count_d = '0;
      out_d   = 1'b0;
      if (pending_d) begin
        active_d  = shadow_d;
        pending_d = 1'b0;
      end
    end else if (bus.enable) begin
      if (terminal) begin
        count_d = '0;
        out_d   = ~out_q;
        tick_d  = 1'b1;
        rise_d  = ~out_q;
        fall_d  = out_q;
        if (pending_d) begin
          active_d  = shadow_d;
          pending_d = 1'b0;
        end
      end else begin
        count_d = count + ONE;
      end
    end
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      active_n  <= RST_N_VAL;
      shadow_n  <= RST_N_VAL;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      count     <= count_d;
      active_n  <= active_d;
      shadow_n  <= shadow_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign bus.out_clk   = out_q;
  assign bus.tick      = tick_q;
  assign bus.rise_tick = rise_q;
  assign bus.fall_tick = fall_q;
  assign bus.pending   = pending_q;

endmodule
